// File: rtl/if_prefetch_queue_if.sv
// Bus bundle for if_prefetch_queue: instruction-memory request/response,
// EX-stage redirect and the decode-side valid/ready handoff.
interface if_prefetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    logic                       imem_req_o;
    logic [XLEN-1:0]            imem_addr_o;
    logic                       imem_gnt_i;
    logic                       imem_rvalid_i;
    logic [31:0]                imem_rdata_i;
    logic                       redirect_i;
    logic [XLEN-1:0]            redirect_addr_i;
    logic                       id_valid_o;
    logic                       id_ready_i;
    logic [31:0]                id_instr_o;
    logic [XLEN-1:0]            id_pc_o;
    logic [XLEN-1:0]            id_pc_next_o;
    logic [$clog2(DEPTH+1)-1:0] count_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  redirect_i, redirect_addr_i,
        output id_valid_o, id_instr_o, id_pc_o, id_pc_next_o,
        input  id_ready_i,
        output count_o
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output redirect_i, redirect_addr_i,
        input  id_valid_o, id_instr_o, id_pc_o, id_pc_next_o,
        output id_ready_i,
        input  count_o
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: in-order req/gnt/rvalid fetch into a DEPTH-entry
// {pc, instr} FIFO with redirect flush. Define IF_PREFETCH_BYPASS_EN for the empty-queue bypass.
module if_prefetch_queue #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input logic                 clk,
    input logic                 rst_n,
    if_prefetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   discard;
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [31:0]     q_instr [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic          req;
    logic          grant;
    logic          resp_ok;
    logic          resp_live;
    logic          bypass_show;
    logic          bypass_take;
    logic          push;
    logic          pop;
    logic [OW-1:0] outstanding_next;

    // Requests are throttled so every in-flight word already owns a queue slot.
    always_comb begin
        req = rst_n && !bus.redirect_i
              && (32'(outstanding) < MAX_OUTSTANDING)
              && ((32'(count) + 32'(outstanding)) < DEPTH);
        grant     = req && bus.imem_gnt_i;
        resp_ok   = bus.imem_rvalid_i && (outstanding != '0);
        resp_live = resp_ok && (discard == '0) && !bus.redirect_i;
        outstanding_next = outstanding + OW'(grant) - OW'(resp_ok);
`ifdef IF_PREFETCH_BYPASS_EN
        bypass_show = resp_live && (count == '0);
        bypass_take = bypass_show && bus.id_ready_i;
`else
        bypass_show = 1'b0;
        bypass_take = 1'b0;
`endif
        push = resp_live && !bypass_take;
        pop  = (count != '0) && bus.id_ready_i && !bus.redirect_i;
    end

    assign bus.imem_req_o   = req;
    assign bus.imem_addr_o  = fetch_pc;
    assign bus.id_valid_o   = (count != '0) || bypass_show;
    assign bus.id_instr_o   = bypass_show ? bus.imem_rdata_i : q_instr[rd_ptr];
    assign bus.id_pc_o      = bypass_show ? resp_pc : q_pc[rd_ptr];
    assign bus.id_pc_next_o = bus.id_pc_o + XLEN'(4);
    assign bus.count_o      = count;

    // Redirect wins over everything: flush the queue and mark all in-flight words stale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (bus.redirect_i) begin
            fetch_pc    <= bus.redirect_addr_i & ~XLEN'(3);
            resp_pc     <= bus.redirect_addr_i & ~XLEN'(3);
            outstanding <= outstanding_next;
            discard     <= outstanding_next;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            outstanding <= outstanding_next;
            if (resp_ok && (discard != '0)) begin
                discard <= discard - OW'(1);
            end
            if (resp_live) begin
                resp_pc <= resp_pc + XLEN'(4);
            end
            if (push) begin
                q_pc[wr_ptr]    <= resp_pc;
                q_instr[wr_ptr] <= bus.imem_rdata_i;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // A response with nothing in flight is a memory-side protocol error.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.imem_rvalid_i && (outstanding == '0)));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue (DEPTH=4, MAX_OUTSTANDING=2, RESET_PC=0):
// a cycle table for streaming/backpressure plus hand sequences for stall, redirect, wrap and reset.
module tb_if_prefetch_queue;
`ifdef IF_PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    if_prefetch_queue_if #(.XLEN(32), .DEPTH(4)) bus ();

    if_prefetch_queue #(
        .XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        int          exp_count;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0013;
    endfunction

    task automatic add_vec(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                           input logic ready, input logic exp_req, input logic [31:0] exp_addr,
                           input logic exp_valid, input logic [31:0] exp_pc, input int exp_count);
        vec_t v;
        v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata; v.ready = ready;
        v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_valid = exp_valid;
        v.exp_pc = exp_pc; v.exp_count = exp_count;
        tbl.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are observed 1ns later, mid-cycle.
    task automatic applyStimulus(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                                 input logic redirect, input logic [31:0] raddr, input logic ready);
        @(negedge clk);
        bus.imem_gnt_i      = gnt;
        bus.imem_rvalid_i   = rvalid;
        bus.imem_rdata_i    = rdata;
        bus.redirect_i      = redirect;
        bus.redirect_addr_i = raddr;
        bus.id_ready_i      = ready;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic check_head(input string tag, input logic exp_valid,
                              input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        checkOutput({tag, "_valid"}, 32'(bus.id_valid_o), 32'(exp_valid));
        if (exp_valid) begin
            checkOutput({tag, "_pc"}, bus.id_pc_o, exp_pc);
            checkOutput({tag, "_instr"}, bus.id_instr_o, exp_instr);
            checkOutput({tag, "_pc_next"}, bus.id_pc_next_o, exp_pc + 32'd4);
        end
    endtask

    task automatic check_req(input string tag, input logic exp_req, input logic [31:0] exp_addr);
        checkOutput({tag, "_req"}, 32'(bus.imem_req_o), 32'(exp_req));
        if (exp_req) checkOutput({tag, "_addr"}, bus.imem_addr_o, exp_addr);
    endtask

    initial begin
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
        bus.redirect_i = 1'b0; bus.redirect_addr_i = '0; bus.id_ready_i = 1'b0;

        // gnt, rvalid, rdata, ready | req, addr, valid, pc, count
        add_vec(1, 0, 0,                 1, 1, 32'd0,  0,   32'd0,  0);
        add_vec(1, 1, word_at(32'd0),    0, 1, 32'd4,  BYP, 32'd0,  0);
        add_vec(1, 1, word_at(32'd4),    1, 1, 32'd8,  1,   32'd0,  1);
        add_vec(1, 1, word_at(32'd8),    1, 1, 32'd12, 1,   32'd4,  1);
        add_vec(1, 1, word_at(32'd12),   0, 1, 32'd16, 1,   32'd8,  1);
        add_vec(1, 1, word_at(32'd16),   0, 1, 32'd20, 1,   32'd8,  2);
        add_vec(1, 1, word_at(32'd20),   0, 0, 32'd24, 1,   32'd8,  3);
        add_vec(1, 0, 0,                 0, 0, 32'd24, 1,   32'd8,  4);
        add_vec(1, 0, 0,                 0, 0, 32'd24, 1,   32'd8,  4);
        add_vec(1, 0, 0,                 1, 0, 32'd24, 1,   32'd8,  4);
        add_vec(1, 0, 0,                 1, 1, 32'd24, 1,   32'd12, 3);
        add_vec(1, 1, word_at(32'd24),   1, 1, 32'd28, 1,   32'd16, 2);
        add_vec(0, 1, word_at(32'd28),   1, 1, 32'd32, 1,   32'd20, 2);
        add_vec(0, 0, 0,                 1, 1, 32'd32, 1,   32'd24, 2);
        add_vec(0, 0, 0,                 1, 1, 32'd32, 1,   32'd28, 1);
        add_vec(0, 0, 0,                 0, 1, 32'd32, 0,   32'd0,  0);

        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        check_req("reset", 1'b0, 32'd0);
        checkOutput("reset_addr", bus.imem_addr_o, 32'd0);
        checkOutput("reset_valid", 32'(bus.id_valid_o), 32'd0);
        checkOutput("reset_instr", bus.id_instr_o, 32'd0);
        checkOutput("reset_pc", bus.id_pc_o, 32'd0);
        checkOutput("reset_pc_next", bus.id_pc_next_o, 32'd4);
        checkOutput("reset_count", 32'(bus.count_o), 32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, 1'b0, 32'd0, tbl[i].ready);
            check_req($sformatf("vec%0d", i), tbl[i].exp_req, tbl[i].exp_addr);
            check_head($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_pc, word_at(tbl[i].exp_pc));
            checkOutput($sformatf("vec%0d_count", i), 32'(bus.count_o), 32'(tbl[i].exp_count));
        end

        // Grant stall: address holds at 0x10 until accepted.
        applyStimulus(0, 0, 0, 1, 32'h13, 0);
        check_req("stall_redir", 1'b0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            check_req($sformatf("stall%0d", k), 1'b1, 32'h10);
            checkOutput($sformatf("stall%0d_valid", k), 32'(bus.id_valid_o), 32'd0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0);
        check_req("stall_gnt", 1'b1, 32'h10);
        applyStimulus(0, 1, word_at(32'h10), 0, 0, 0);
        check_head("stall_resp", BYP, 32'h10, word_at(32'h10));
        applyStimulus(0, 0, 0, 0, 0, 1);
        check_head("stall_head", 1'b1, 32'h10, word_at(32'h10));
        checkOutput("stall_count", 32'(bus.count_o), 32'd1);

        // Two stale in-flight words squashed by a redirect to 0x103.
        applyStimulus(0, 0, 0, 1, 32'h20, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        check_req("sq_g0", 1'b1, 32'h20);
        applyStimulus(1, 0, 0, 0, 0, 0);
        check_req("sq_g1", 1'b1, 32'h24);
        applyStimulus(1, 0, 0, 1, 32'h103, 0);
        check_req("sq_redir", 1'b0, 32'd0);
        applyStimulus(1, 1, word_at(32'h20), 0, 0, 0);
        check_req("sq_stale0", 1'b0, 32'd0);
        checkOutput("sq_stale0_valid", 32'(bus.id_valid_o), 32'd0);
        applyStimulus(1, 1, word_at(32'h24), 0, 0, 0);
        check_req("sq_stale1", 1'b1, 32'h100);
        checkOutput("sq_stale1_valid", 32'(bus.id_valid_o), 32'd0);
        applyStimulus(0, 1, 32'h1234_5678, 0, 0, 0);
        check_req("sq_live", 1'b1, 32'h104);
        applyStimulus(0, 0, 0, 0, 0, 1);
        check_head("sq_head", 1'b1, 32'h100, 32'h1234_5678);
        checkOutput("sq_count", 32'(bus.count_o), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        check_head("sq_empty", 1'b0, 32'd0, 32'd0);

        // Redirect coinciding with rvalid and pop.
        applyStimulus(1, 0, 0, 0, 0, 0);
        check_req("rp_g0", 1'b1, 32'h104);
        applyStimulus(1, 1, word_at(32'h104), 0, 0, 0);
        check_req("rp_g1", 1'b1, 32'h108);
        applyStimulus(1, 1, word_at(32'h108), 1, 32'h200, 1);
        check_req("rp_redir", 1'b0, 32'd0);
        check_head("rp_redir", 1'b1, 32'h104, word_at(32'h104));
        applyStimulus(0, 0, 0, 0, 0, 1);
        check_head("rp_after", 1'b0, 32'd0, 32'd0);
        checkOutput("rp_after_count", 32'(bus.count_o), 32'd0);
        check_req("rp_after", 1'b1, 32'h200);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, word_at(32'h200), 0, 0, 0);
        check_head("rp_resp", BYP, 32'h200, word_at(32'h200));
        applyStimulus(0, 0, 0, 0, 0, 0);
        check_head("rp_head", 1'b1, 32'h200, word_at(32'h200));

        // PC wrap at the top of the address space.
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        check_req("wrap_g", 1'b1, 32'hFFFF_FFFC);
        applyStimulus(0, 1, word_at(32'hFFFF_FFFC), 0, 0, 0);
        check_req("wrap_next", 1'b1, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        check_head("wrap_head", 1'b1, 32'hFFFF_FFFC, word_at(32'hFFFF_FFFC));

        // Reset in the middle of traffic.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, word_at(32'h0), 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        check_req("mrst", 1'b0, 32'd0);
        checkOutput("mrst_addr", bus.imem_addr_o, 32'd0);
        checkOutput("mrst_valid", 32'(bus.id_valid_o), 32'd0);
        checkOutput("mrst_pc", bus.id_pc_o, 32'd0);
        checkOutput("mrst_instr", bus.id_instr_o, 32'd0);
        checkOutput("mrst_count", 32'(bus.count_o), 32'd0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        check_req("mrst_rel", 1'b1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
